// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared constants, state encoding and ID type for the
//                four-requester arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef logic [1:0] req_id_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_prio_enc4.sv
`default_nettype none
// ============================================================================
//  Module      : arb_prio_enc4
//  Description : Combinational 4-to-2 priority encoder.
//                - Bit 3 has the highest priority.
//                - When ARB_ROUND_ROBIN_EN is defined, the request vector is
//                  rotated so the search starts at i_offset+1 and runs upward
//                  (mod 4). The fixed encoder is then applied, and its result
//                  is un-rotated.
//  Ports       : i_req    [3:0] request vector
//                i_offset [1:0] last winner (round-robin build only)
//                o_id     [1:0] winning index
//                o_any          at least one request is set
//  Macro       : ARB_ROUND_ROBIN_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_prio_enc4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  req_id_t         i_offset,
`endif
    output req_id_t         o_id,
    output logic            o_any
);

    logic [NREQ-1:0] w_vec;
    req_id_t         w_enc;

`ifdef ARB_ROUND_ROBIN_EN
    // The rotated bit (3-k) carries req[offset+1+k]. As a result, the
    // highest-first encoder picks the first requester found searching upward
    // from offset+1. Un-rotating gives: id = (offset+1+(3-enc)) mod 4,
    // which simplifies to offset - enc (mod 4).
    always_comb begin
        w_vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_vec[NREQ-1-k] = i_req[2'(i_offset + 2'(k) + 2'd1)];
        end
    end
    assign o_id = req_id_t'(i_offset - w_enc);
`else
    assign w_vec = i_req;
    assign o_id  = w_enc;
`endif

    always_comb begin
        w_enc = 2'd0;
        if (w_vec[3])      w_enc = 2'd3;
        else if (w_vec[2]) w_enc = 2'd2;
        else if (w_vec[1]) w_enc = 2'd1;
        else               w_enc = 2'd0;
    end

    assign o_any = |i_req;

endmodule : arb_prio_enc4
`default_nettype wire

// File: rtl/arb4_controller.sv
`default_nettype none
// ============================================================================
//  Module      : arb4_controller
//  Description : Four-requester arbiter with registered one-hot grant.
//                - Once granted, the owner keeps the grant until it drops
//                  its request or until HOLD_MAX cycles have elapsed.
//                - At least one idle cycle always separates two grants.
//  Ports       : clk            rising-edge clock
//                rst            synchronous active-high reset
//                req     [3:0]  level-sensitive request lines
//                gnt     [3:0]  one-hot grant
//                gnt_id  [1:0]  encoded owner (0 when idle)
//                gnt_vld        |gnt
//                timeout        one-cycle pulse on a HOLD_MAX release
//  Macro       : ARB_ROUND_ROBIN_EN (round-robin instead of fixed 3>2>1>0)
//  Revision    : 1.0 - initial release
// ============================================================================
module arb4_controller
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output req_id_t         gnt_id,
    output logic            gnt_vld,
    output logic            timeout
);

    localparam bit               c_TO_EN     = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    arb_state_t       r_state,   w_state_nxt;
    logic [NREQ-1:0]  r_gnt,     w_gnt_nxt;
    req_id_t          r_gnt_id,  w_gnt_id_nxt;
    logic             r_vld,     w_vld_nxt;
    logic             r_to,      w_to_nxt;
    logic [CNT_W-1:0] r_hold,    w_hold_nxt;

    req_id_t          w_win;
    logic             w_any;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t          r_rr_ptr,  w_rr_ptr_nxt;

    arb_prio_enc4 u_enc (
        .i_req    (req),
        .i_offset (r_rr_ptr),
        .o_id     (w_win),
        .o_any    (w_any)
    );
`else
    arb_prio_enc4 u_enc (
        .i_req    (req),
        .o_id     (w_win),
        .o_any    (w_any)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_vld    <= 1'b0;
            r_to     <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_vld    <= w_vld_nxt;
            r_to     <= w_to_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) r_rr_ptr <= '0;
        else     r_rr_ptr <= w_rr_ptr_nxt;
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_vld_nxt    = r_vld;
        w_to_nxt     = 1'b0;
        w_hold_nxt   = r_hold;
`ifdef ARB_ROUND_ROBIN_EN
        w_rr_ptr_nxt = r_rr_ptr;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = NREQ'(1) << w_win;
                    w_gnt_id_nxt = w_win;
                    w_vld_nxt    = 1'b1;
                    w_hold_nxt   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    w_rr_ptr_nxt = w_win;
`endif
                end
            end
            GRANT: begin
                // A client drop wins over a coincident timeout, so the pulse
                // is raised only when the owner is still requesting.
                if (!req[r_gnt_id] || (c_TO_EN && (r_hold == c_HOLD_LAST))) begin
                    w_state_nxt  = IDLE;
                    w_gnt_nxt    = '0;
                    w_gnt_id_nxt = '0;
                    w_vld_nxt    = 1'b0;
                    w_hold_nxt   = '0;
                    w_to_nxt     = req[r_gnt_id];
                end else begin
                    w_hold_nxt   = r_hold + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = r_vld;
    assign timeout = r_to;

endmodule : arb4_controller
`default_nettype wire

// File: tb/tb_arb4_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb4_controller
//  Description : Self-checking bench for arb4_controller (HOLD_MAX = 4).
//  Macro       : ARB_ROUND_ROBIN_EN selects the round-robin expectations
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb4_controller;

    localparam int c_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int n_pass = 0;
    int n_tot  = 0;

    arb4_controller #(.HOLD_MAX(c_HOLD), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int row, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        @(negedge clk);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifndef ARB_ROUND_ROBIN_EN
        //                   rst   req      gnt      id    vld   to
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0}); // reset, req held
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0}); // first grant: 3
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}); // drop -> release
        tbl.push_back('{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0}); // 2 beats 0
        tbl.push_back('{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0}); // drop 2
        tbl.push_back('{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0}); // then 0
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0}); // timeout run
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1}); // timeout pulse
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0}); // re-grant
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1}); // period 5
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}); // drop on last: no pulse
        tbl.push_back('{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0}); // no preemption
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0}); // reset mid-grant
        tbl.push_back('{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0}); // 1-cycle re-grant
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0});
`else
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0}); // search 1,2,3,0
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0}); // ptr=1 -> 2
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0}); // ptr=2 -> 0
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0});
`endif

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req);
            check("gnt",     i, int'(gnt),     int'(tbl[i].gnt));
            check("gnt_id",  i, int'(gnt_id),  int'(tbl[i].id));
            check("gnt_vld", i, int'(gnt_vld), int'(tbl[i].vld));
            check("timeout", i, int'(timeout), int'(tbl[i].to));
        end

`ifndef ARB_ROUND_ROBIN_EN
        // Hold req[2] until the timeout pulse; count grant-high cycles.
        begin
            int  cnt  = 0;
            bit  seen = 0;
            @(negedge clk);
            req = 4'b0100;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (gnt == 4'b0100) cnt++;
                if (timeout) seen = 1;
            end
            check("to_seen",  100, int'(seen), 1);
            check("hold_len", 100, cnt, c_HOLD);
            @(posedge clk);
            #1;
            check("regrant_gnt", 101, int'(gnt), 4'b0100);
            check("regrant_to",  101, int'(timeout), 0);
            step(1'b0, 4'b0000);
            check("final_gnt", 102, int'(gnt), 0);
        end
`else
        // req=1111 constant: successive grants rotate 1,2,3,0,1.
        begin
            logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            @(negedge clk);
            rst = 1'b1;
            req = 4'b1111;
            @(negedge clk);
            rst = 1'b0;
            for (int g = 0; g < 5; g++) begin
                bit got = 0;
                for (int c = 0; c < 20 && !got; c++) begin
                    @(posedge clk);
                    #1;
                    if (gnt_vld) got = 1;
                end
                check("rr_grant_seen", 200 + g, int'(got), 1);
                check("rr_grant_id",   200 + g, int'(gnt_id), int'(exp_seq[g]));
                for (int c = 0; c < 20 && gnt_vld; c++) begin
                    @(posedge clk);
                    #1;
                end
            end
            @(negedge clk);
            req = 4'b0000;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_arb4_controller
`default_nettype wire
